// File: rtl/regfile_scoreboard.sv
// 32 x XLEN integer register file with write-first bypass and a per-register
// pending-write scoreboard that flags operand hazards to issue.
module regfile_scoreboard #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data,
  input  logic            lock_en,
  input  logic [AW-1:0]   lock_addr,
  output logic            rs1_busy,
  output logic            rs2_busy
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_pending;

  logic w_wrValid;
  logic w_lockValid;
  logic w_rs1Bypass;
  logic w_rs2Bypass;

  assign w_wrValid   = we && (rd_addr != '0);
  assign w_lockValid = lock_en && (lock_addr != '0);
  assign w_rs1Bypass = w_wrValid && (rd_addr == rs1_addr);
  assign w_rs2Bypass = w_wrValid && (rd_addr == rs2_addr);

  // Entry 0 is cleared on reset and never written, so x0 always reads as zero;
  // the lock is applied after the clear so a same-cycle set wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_pending <= '0;
    end else begin
      if (w_wrValid) begin
        r_regs[rd_addr]    <= rd_data;
        r_pending[rd_addr] <= 1'b0;
      end
      if (w_lockValid) begin
        r_pending[lock_addr] <= 1'b1;
      end
    end
  end

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (rs1_addr != '0) begin
      rs1_data = w_rs1Bypass ? rd_data : r_regs[rs1_addr];
      rs1_busy = r_pending[rs1_addr] && !w_rs1Bypass;
    end
    if (rs2_addr != '0) begin
      rs2_data = w_rs2Bypass ? rd_data : r_regs[rs2_addr];
      rs2_busy = r_pending[rs2_addr] && !w_rs2Bypass;
    end
  end

endmodule
